// File: rtl/fc_pkg.sv
// fc_pkg -- shared definitions for the fully-connected MAC sequencer.
//   fc_state_e    : controller states (IDLE / ACC / DONE)
//   FC_N_DEFAULT  : default signed operand width
//   FC_K_DEFAULT  : default vector dimension (products per dot product)
//   idx_width()   : width of the element index counter (at least 1 bit)
package fc_pkg;

  localparam int FC_N_DEFAULT = 8;
  localparam int FC_K_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } fc_state_e;

  // A one-element vector still needs a 1-bit index port.
  function automatic int idx_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/mac_comb.sv
// mac_comb -- combinational multiply-accumulate step.
//   acc_i [L] : current signed accumulator value
//   a_i   [N] : signed operand
//   b_i   [N] : signed operand
//   sum_o [L] : acc_i + (a_i * b_i), product truncated to 2N-1 bits,
//               sign-extended to L bits, sum wrapping modulo 2^L
// L is assumed to be at least 2N-1 bits wide.
module mac_comb #(
  parameter int N = 8,
  parameter int K = 3,
  parameter int L = 2*(N-1)+K
) (
  input  logic signed [N-1:0] a_i,
  input  logic signed [N-1:0] b_i,
  input  logic signed [L-1:0] acc_i,
  output logic signed [L-1:0] sum_o
);

  localparam int PW = 2*N-1;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;

  // Multiplying at 2N-1 bits keeps only the low product bits, so the single
  // overflowing case (-2^(N-1))^2 wraps to -2^(2N-2).
  assign a_ext = PW'(a_i);
  assign b_ext = PW'(b_i);
  assign prod  = a_ext * b_ext;
  assign sum_o = acc_i + L'(prod);

endmodule

// File: rtl/fc_mac_seq.sv
// fc_mac_seq -- sequential K-element signed dot product with valid/ready I/O.
//   clk, rst      : clock, synchronous active-high reset
//   start         : begin a new dot product (honoured in IDLE, or in DONE
//                   together with out_ready)
//   in_valid/in_ready, A, B : operand pair handshake
//   out_valid/out_ready, S  : result handshake, S held until accepted
//   busy          : controller not in IDLE
//   elem_idx      : index of the next operand pair to be accepted
// Build option: define FC_RELU_EN to clamp negative results of S to zero
// (the internal accumulator keeps its true value).
module fc_mac_seq
  import fc_pkg::*;
#(
  parameter int N = FC_N_DEFAULT,
  parameter int K = FC_K_DEFAULT,
  parameter int L = 2*(N-1)+K
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [N-1:0]       A,
  input  logic signed [N-1:0]       B,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [L-1:0]       S,
  output logic                      busy,
  output logic [idx_width(K)-1:0]   elem_idx
);

  localparam int IW = idx_width(K);

  fc_state_e           state_q;
  logic signed [L-1:0] acc_q;
  logic signed [L-1:0] acc_d;
  logic [IW-1:0]       idx_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                busy_q;

  mac_comb #(
    .N(N),
    .K(K),
    .L(L)
  ) u_mac (
    .a_i  (A),
    .b_i  (B),
    .acc_i(acc_q),
    .sum_o(acc_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= ACC;
            acc_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ACC: begin
          // in_ready is always high here, so in_valid alone is the handshake.
          if (in_valid) begin
            acc_q <= acc_d;
            if (idx_q == IW'(K-1)) begin
              state_q     <= DONE;
              idx_q       <= '0;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (start) begin
              // Back-to-back: result consumed and next vector begins at once.
              state_q    <= ACC;
              acc_q      <= '0;
              idx_q      <= '0;
              in_ready_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          acc_q       <= '0;
          idx_q       <= '0;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign elem_idx  = idx_q;

`ifdef FC_RELU_EN
  assign S = acc_q[L-1] ? '0 : acc_q;
`else
  assign S = acc_q;
`endif

endmodule

// File: tb/tb_fc_mac_seq.sv
// tb_fc_mac_seq -- self-checking bench for fc_mac_seq (N=8, K=3, L=17).
// A transaction-level reference tracks phase, accumulated dot product and
// next index using plain integer arithmetic; a negedge process compares the
// DUT against it every cycle. Directed runs pin known results literally,
// then randomized runs exercise bubbles, stalls, ignored starts and resets.
module tb_fc_mac_seq;

  localparam int N = 8;
  localparam int K = 3;
  localparam int L = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [N-1:0] A = '0;
  logic signed [N-1:0] B = '0;
  logic in_ready;
  logic out_valid;
  logic busy;
  logic signed [L-1:0] S;
  logic [1:0] elem_idx;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fc_mac_seq #(.N(N), .K(K), .L(L)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .S        (S),
    .busy     (busy),
    .elem_idx (elem_idx)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Two's-complement wrap of v into a signed field of the given width.
  function automatic longint wrap(input longint v, input int bits);
    longint m;
    longint r;
    m = longint'(1) <<< bits;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic longint relu(input longint v);
`ifdef FC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Reference: 0 = idle, 1 = collecting pairs, 2 = result pending.
  int     m_ph = 0;
  longint m_acc = 0;
  int     m_idx = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_acc = 0; m_idx = 0;
    end else if (m_ph == 0) begin
      if (start) begin m_ph = 1; m_acc = 0; m_idx = 0; end
    end else if (m_ph == 1) begin
      if (in_valid) begin
        m_acc = wrap(m_acc + wrap(longint'(A) * longint'(B), 2*N-1), L);
        m_idx++;
        if (m_idx == K) begin m_ph = 2; m_idx = 0; end
      end
    end else begin
      if (out_ready) begin
        if (start) begin m_ph = 1; m_acc = 0; m_idx = 0; end
        else m_ph = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", longint'(busy), longint'(m_ph != 0));
    check("in_ready", longint'(in_ready), longint'(m_ph == 1));
    check("out_valid", longint'(out_valid), longint'(m_ph == 2));
    if (m_ph != 2) check("elem_idx", longint'(elem_idx), longint'(m_idx));
    if (m_ph == 2) check("S_model", longint'(S), relu(m_acc));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int a, input int b, input int bubbles);
    repeat (bubbles) cyc();
    A = 8'(a); B = 8'(b); in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic run(input bit do_start, input int a0, input int b0,
                     input int a1, input int b1, input int a2, input int b2,
                     input int bubbles, input longint exp_s, input string name);
    if (do_start) begin
      start = 1'b1; cyc(); start = 1'b0;
    end
    send(a0, b0, bubbles);
    send(a1, b1, bubbles);
    send(a2, b2, bubbles);
    check({name, "_latency"}, longint'(out_valid), 1);
    check(name, longint'(S), exp_s);
  endtask

  task automatic consume(input int delay);
    repeat (delay) cyc();
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
  endtask

  initial begin
    repeat (3) cyc();
    check("rst_S", longint'(S), 0);
    check("rst_busy", longint'(busy), 0);
    rst = 1'b0;
    cyc();

    run(1'b1, 1, 2, 3, 4, 5, 6, 0, 44, "S_44");
    consume(0);
`ifdef FC_RELU_EN
    run(1'b1, -3, 5, 2, 2, 0, 7, 0, 0, "S_neg11");
`else
    run(1'b1, -3, 5, 2, 2, 0, 7, 0, -11, "S_neg11");
`endif
    consume(1);

    // Bubbles, then a stalled consumer with start held high meanwhile.
    run(1'b1, 1, 2, 3, 4, 5, 6, 2, 44, "S_44_bubbles");
    repeat (5) begin
      start = 1'b1; cyc();
      check("hold_S", longint'(S), 44);
      check("hold_valid", longint'(out_valid), 1);
    end
    out_ready = 1'b1; start = 1'b1; cyc();
    out_ready = 1'b0; start = 1'b0;
    check("b2b_busy", longint'(busy), 1);
    check("b2b_in_ready", longint'(in_ready), 1);
    check("b2b_idx", longint'(elem_idx), 0);
    check("b2b_acc", longint'(S), 0);
    run(1'b0, 1, 2, 3, 4, 5, 6, 0, 44, "S_44_b2b");
    consume(0);

    // Reset in the middle of accumulation discards the partial sum.
    start = 1'b1; cyc(); start = 1'b0;
    send(7, 7, 0);
    send(9, 9, 0);
    rst = 1'b1; start = 1'b1; cyc(); rst = 1'b0; start = 1'b0;
    check("midrst_busy", longint'(busy), 0);
    check("midrst_valid", longint'(out_valid), 0);
    check("midrst_S", longint'(S), 0);
    run(1'b1, 1, 2, 3, 4, 5, 6, 0, 44, "S_44_after_rst");
    consume(0);

`ifdef FC_RELU_EN
    run(1'b1, -128, -128, -128, -128, -128, -128, 0, 0, "S_wrap_min");
`else
    run(1'b1, -128, -128, -128, -128, -128, -128, 0, -49152, "S_wrap_min");
`endif
    consume(0);
    run(1'b1, 127, 127, 127, 127, 127, 127, 0, 48387, "S_max");
    consume(2);

    // Randomized runs; the reference model judges every cycle.
    for (int r = 0; r < 40; r++) begin
      start = 1'b1; cyc(); start = 1'b0;
      for (int p = 0; p < K; p++) begin
        for (int g = 0; g < int'($urandom_range(2)); g++) begin
          start = 1'($urandom);
          cyc();
        end
        start = 1'b0;
        A = 8'($urandom); B = 8'($urandom); in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        if (p == 0 && $urandom_range(7) == 0) begin
          rst = 1'b1; cyc(); rst = 1'b0;
          break;
        end
      end
      if (out_valid) begin
        for (int d = 0; d < int'($urandom_range(3)); d++) begin
          start = 1'($urandom); cyc();
        end
        start = 1'b0;
        consume(0);
      end
    end

    // Leave the DUT idle within a bounded number of cycles.
    for (int w = 0; w < 20 && busy; w++) begin
      out_ready = 1'b1; cyc();
    end
    out_ready = 1'b0;
    check("final_idle", longint'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fc_mac_seq.md
FC_MAC_SEQ -- requirements
Module: fc_mac_seq

Interface
REQ-001 SHALL have parameter N, default 8: signed input operand bit-width.
REQ-002 SHALL have parameter K, default 3: vector dimension, i.e. products per dot product (K >= 1).
REQ-003 SHALL have parameter L, default 2*(N-1)+K: accumulator/result bit-width.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  in  1  request a new dot product.
REQ-007 SHALL have port in_valid  in  1  operand pair A/B present.
REQ-008 SHALL have port in_ready  out  1  block accepts an operand pair.
REQ-009 SHALL have port A  in  N  signed operand.
REQ-010 SHALL have port B  in  N  signed operand.
REQ-011 SHALL have port out_valid  out  1  result S valid.
REQ-012 SHALL have port out_ready  in  1  consumer accepts S.
REQ-013 SHALL have port S  out  L  signed dot-product result.
REQ-014 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-015 SHALL have port elem_idx  out  $clog2(K) (min 1)  index of next pair to be accepted.

Function
REQ-016 SHALL implement FSM states IDLE, ACC, DONE.
REQ-017 IDLE: in_ready=0, out_valid=0; start=1 -> ACC with acc=0, elem_idx=0.
REQ-018 ACC: in_ready=1; handshake (in_valid & in_ready) SHALL do acc <= acc + A*B and elem_idx++.
REQ-019 ACC: cycles with in_valid=0 SHALL leave acc and elem_idx unchanged.
REQ-020 Handshake with elem_idx==K-1 SHALL go to DONE; with K=1 the first handshake goes to DONE.
REQ-021 DONE: out_valid=1, in_ready=0; S and out_valid SHALL hold stable until out_ready=1.
REQ-022 DONE with out_ready=1 SHALL go to IDLE; if start=1 in the same cycle, go directly to ACC with acc=0, elem_idx=0.
REQ-023 start SHALL be ignored in ACC, and in DONE without out_ready.
REQ-024 Latency: out_valid SHALL rise in the cycle after the K-th handshake.
REQ-025 Product SHALL be 2N-1 bits signed, two's-complement truncated; (-2^(N-1))*(-2^(N-1)) therefore wraps to -2^(2N-2).
REQ-026 Accumulation SHALL be L bits, sign-extending the product, wrapping modulo 2^L with no saturation.

Reset
REQ-027 rst=1 SHALL force IDLE, acc=0, elem_idx=0, out_valid=0, in_ready=0, busy=0, S=0 at the next edge.
REQ-028 rst mid-ACC or mid-DONE SHALL discard the partial or pending result; rst SHALL take priority over start.

Configuration
REQ-029 Macro FC_RELU_EN defined: S SHALL be 0 when acc is negative, otherwise acc; internal acc itself is unaffected.
REQ-030 Macro FC_RELU_EN undefined: S SHALL equal acc unmodified.

Structure
REQ-031 Package fc_pkg SHALL hold the FSM state enum typedef (IDLE/ACC/DONE) and the default N/K constants.
REQ-032 The block SHALL instantiate existing sub-module mac_comb (N, K, L passed through) for the product-add; fc_mac_seq holds only FSM, counter and accumulator register.

Verification (N=8, K=3, L=17)
REQ-033 start; pairs (1,2),(3,4),(5,6) back-to-back -> out_valid one cycle after 3rd handshake, S=44.
REQ-034 pairs (-3,5),(2,2),(0,7) -> S=-11 without FC_RELU_EN; S=0 with it.
REQ-035 in_valid bubbles between pairs of REQ-033 -> elem_idx advances only on handshakes, S=44; out_ready low 5 cycles -> S held at 44, start ignored; then out_ready and start together -> ACC, acc=0.
REQ-036 rst asserted after 2 handshakes -> next cycle IDLE, busy=0, out_valid=0; subsequent run of REQ-033 -> S=44.
REQ-037 pairs (-128,-128) x3 -> each product wraps to -16384, S=-49152 (no RELU); (127,127) x3 -> S=48387.
